// File: rtl/io_register_bank.sv
// io_register_bank: CPU-visible register bank with NUM_RW writable registers,
// NUM_RO read-only peripheral inputs, self-clearing strobe registers, a sticky
// write-1-to-clear event register and a masked interrupt output.
// Optional build macro: REG_BANK_READ_PIPE_EN registers both read ports
// (1-cycle read latency). When it is undefined, reads are combinational.
module io_register_bank #(
    parameter int                DATA_W      = 8,
    parameter int                ADDR_W      = 6,
    parameter int                NUM_RW      = 32,
    parameter int                RO_BASE     = 32,
    parameter int                NUM_RO      = 8,
    parameter logic [NUM_RW-1:0] STROBE_MASK = '0,
    parameter int                EVT_ADDR    = 40,
    parameter int                IRQ_MSK_REG = 31
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     w_enable,
    input  logic [ADDR_W-1:0]        w_addr,
    input  logic [DATA_W-1:0]        w_data,
    input  logic [ADDR_W-1:0]        r_addr_a,
    input  logic [ADDR_W-1:0]        r_addr_b,
    output logic [DATA_W-1:0]        r_data_a,
    output logic [DATA_W-1:0]        r_data_b,
    output logic [NUM_RW*DATA_W-1:0] rw_regs,
    input  logic [NUM_RO*DATA_W-1:0] ro_data,
    input  logic [DATA_W-1:0]        event_in,
    output logic [DATA_W-1:0]        evt_status,
    output logic                     irq
);

    logic [DATA_W-1:0] regs [NUM_RW];
    logic [DATA_W-1:0] evt_clr;
    logic [DATA_W-1:0] rd_a;
    logic [DATA_W-1:0] rd_b;

    // RW register file; strobe registers fall back to 0 on any cycle without a write
    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_RW; i++) begin
            if (!rst_n) begin
                regs[i] <= '0;
            end else if (w_enable && (int'(w_addr) == i)) begin
                regs[i] <= w_data;
            end else if (STROBE_MASK[i]) begin
                regs[i] <= '0;
            end
        end
    end

    // W1C clear mask, only active for a write that targets the event register
    always_comb begin
        evt_clr = '0;
        if (w_enable && (int'(w_addr) == EVT_ADDR)) begin
            evt_clr = w_data;
        end
    end

    // Sticky event register; a new event beats a simultaneous clear of the same bit
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            evt_status <= '0;
        end else begin
            evt_status <= (evt_status & ~evt_clr) | event_in;
        end
    end

    assign irq = |(evt_status & regs[IRQ_MSK_REG]);

    for (genvar g = 0; g < NUM_RW; g++) begin : g_flat
        assign rw_regs[g*DATA_W +: DATA_W] = regs[g];
    end

    // Read decode shared by both ports; always the pre-write register state
    always_comb begin
        rd_a = '0;
        rd_b = '0;
        for (int i = 0; i < NUM_RW; i++) begin
            if (int'(r_addr_a) == i) rd_a = regs[i];
            if (int'(r_addr_b) == i) rd_b = regs[i];
        end
        for (int j = 0; j < NUM_RO; j++) begin
            if (int'(r_addr_a) == RO_BASE + j) rd_a = ro_data[j*DATA_W +: DATA_W];
            if (int'(r_addr_b) == RO_BASE + j) rd_b = ro_data[j*DATA_W +: DATA_W];
        end
        if (int'(r_addr_a) == EVT_ADDR) rd_a = evt_status;
        if (int'(r_addr_b) == EVT_ADDR) rd_b = evt_status;
    end

`ifdef REG_BANK_READ_PIPE_EN
    // Registered read ports: data reflects address and state of the previous edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_data_a <= '0;
            r_data_b <= '0;
        end else begin
            r_data_a <= rd_a;
            r_data_b <= rd_b;
        end
    end
`else
    assign r_data_a = rd_a;
    assign r_data_b = rd_b;
`endif

endmodule
